// File: rtl/regfile_z2r1w_clr.sv
// Register file with two combinational read ports and one write port. Entry 0 reads as zero.
// A self-clearing sweep zeroes all entries after reset or clear. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_z2r1w_clr #(
    parameter int p_nregs = 32,
    parameter int p_nbits = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    output logic                       ready,
    input  logic                       wen,
    input  logic [$clog2(p_nregs)-1:0] waddr,
    input  logic [p_nbits-1:0]         wdata,
    input  logic [$clog2(p_nregs)-1:0] raddr0,
    output logic [p_nbits-1:0]         rdata0,
    input  logic [$clog2(p_nregs)-1:0] raddr1,
    output logic [p_nbits-1:0]         rdata1
);

    localparam int AW = $clog2(p_nregs);
    localparam logic [AW-1:0] CTR_FIRST = AW'(1);
    localparam logic [AW-1:0] CTR_LAST  = AW'(p_nregs - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ctr_q, ctr_d;

    logic [p_nbits-1:0] mem_q [1:p_nregs-1];

    logic               mem_we;
    logic [AW-1:0]      mem_wa;
    logic [p_nbits-1:0] mem_wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ctr_q   <= CTR_FIRST;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // clear is only honoured from READY; a clear during the sweep does not restart it.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (ctr_q == CTR_LAST) begin
                    state_d = ST_READY;
                end else begin
                    ctr_d = ctr_q + CTR_FIRST;
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ctr_d   = CTR_FIRST;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Single storage write port shared between the sweep and normal writes.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = waddr;
        mem_wd = wdata;
        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = ctr_q;
            mem_wd = '0;
        end else if (wen && !clear && (waddr != '0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign ready = (state_q == ST_READY);

`ifdef REGFILE_BYPASS_EN
    logic byp_ok;
    assign byp_ok = (state_q == ST_READY) && !clear && wen && (waddr != '0);
`endif

    always_comb begin
        rdata0 = '0;
        rdata1 = '0;
        if (state_q == ST_READY) begin
            if (raddr0 != '0) rdata0 = mem_q[raddr0];
            if (raddr1 != '0) rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
            if (byp_ok && (raddr0 == waddr)) rdata0 = wdata;
            if (byp_ok && (raddr1 == waddr)) rdata1 = wdata;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_z2r1w_clr.sv
// Self-checking bench for regfile_z2r1w_clr: directed vector table, sweep/reset sequences, random traffic.
// Expected values follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_z2r1w_clr;

    localparam int NREGS = 32;
    localparam int NBITS = 32;
    localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic             ready;
    logic             wen = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [NBITS-1:0] wdata = '0;
    logic [AW-1:0]    raddr0 = '0;
    logic [NBITS-1:0] rdata0;
    logic [AW-1:0]    raddr1 = '0;
    logic [NBITS-1:0] rdata1;

    regfile_z2r1w_clr #(.p_nregs(NREGS), .p_nbits(NBITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .ready  (ready),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr0 (raddr0),
        .rdata0 (rdata0),
        .raddr1 (raddr1),
        .rdata1 (rdata1)
    );

    always #5 clk = ~clk;

    int unsigned ncmp = 0;
    int unsigned nerr = 0;

    typedef struct {
        logic             wen;
        logic [AW-1:0]    waddr;
        logic [NBITS-1:0] wdata;
        logic [AW-1:0]    raddr0;
        logic [AW-1:0]    raddr1;
        logic [NBITS-1:0] exp0;
        logic [NBITS-1:0] exp1;
    } vec_t;

    vec_t vecs [9];
    logic [NBITS-1:0] model [NREGS];

    task automatic chk(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that starts a sweep; ready must stay low for 31 samples, then rise.
    task automatic sweep_check(input string name, input bit pulses);
        raddr0 = 5'd3;
        raddr1 = 5'd17;
        for (int k = 0; k < NREGS - 1; k++) begin
            #1;
            chk({name, " ready low"}, {31'd0, ready}, 32'd0);
            chk({name, " rdata0 forced 0"}, rdata0, 32'd0);
            chk({name, " rdata1 forced 0"}, rdata1, 32'd0);
            if (pulses) begin
                wen   = k[0];
                waddr = (k < 16) ? 5'd1 : 5'd2;
                wdata = 32'h5a5a0000 + k;
                clear = (k == 5);
            end
            step();
        end
        wen   = 1'b0;
        clear = 1'b0;
        #1;
        chk({name, " ready high"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < NREGS; i++) begin
            raddr0 = i[AW-1:0];
            raddr1 = 5'(NREGS - 1 - i);
            #1;
            chk({name, " port0"}, rdata0, 32'd0);
            chk({name, " port1"}, rdata1, 32'd0);
        end
    endtask

    initial begin
        int unsigned seed;
        logic [NBITS-1:0] e0, e1;

        vecs[0] = '{1'b1, 5'd5,  32'hdeadbeef, 5'd5,  5'd0, BYP ? 32'hdeadbeef : 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 32'hdeadbeef, 32'hdeadbeef};
        vecs[2] = '{1'b1, 5'd0,  32'hffffffff, 5'd0,  5'd0, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5, BYP ? 32'h12345678 : 32'h0, 32'hdeadbeef};
        vecs[5] = '{1'b1, 5'd5,  32'hcafef00d, 5'd7,  5'd5, 32'h12345678, BYP ? 32'hcafef00d : 32'hdeadbeef};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7, 32'hcafef00d, 32'h12345678};
        vecs[7] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd31, BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1, 32'h1, 32'h0};

        // Reset and initial sweep
        reset = 1'b1;
        step();
        reset = 1'b0;
        sweep_check("reset sweep", 1'b0);
        check_all_zero("post reset");

        // Directed vectors: compare combinational outputs before the edge that commits the write
        foreach (vecs[i]) begin
            wen    = vecs[i].wen;
            waddr  = vecs[i].waddr;
            wdata  = vecs[i].wdata;
            raddr0 = vecs[i].raddr0;
            raddr1 = vecs[i].raddr1;
            #1;
            chk($sformatf("vec%0d rdata0", i), rdata0, vecs[i].exp0);
            chk($sformatf("vec%0d rdata1", i), rdata1, vecs[i].exp1);
            step();
        end
        wen = 1'b0;

        // Fill, then clear with a concurrent write that must be dropped
        for (int i = 1; i < NREGS; i++) begin
            wen   = 1'b1;
            waddr = i[AW-1:0];
            wdata = i * 32'h11111111;
            step();
        end
        wen    = 1'b0;
        raddr0 = 5'd3;
        raddr1 = 5'd31;
        #1;
        chk("fill entry3", rdata0, 32'h33333333);
        chk("fill entry31", rdata1, 32'h1111110f);
        clear  = 1'b1;
        wen    = 1'b1;
        waddr  = 5'd3;
        wdata  = 32'ha;
        #1;
        chk("clear-cycle no bypass", rdata0, 32'h33333333);
        step();
        clear = 1'b0;
        wen   = 1'b0;
        sweep_check("clear sweep", 1'b1);
        check_all_zero("post clear");

        // Reset at sweep cycle 10 restarts the sweep
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 9; k++) step();
        #1;
        chk("mid-sweep ready", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sweep_check("restart sweep", 1'b0);

        // Random traffic against a reference model
        seed = 32'd12345;
        void'($urandom(seed));
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        for (int c = 0; c < 200; c++) begin
            wen    = 1'($urandom_range(1, 0));
            waddr  = 5'($urandom_range(NREGS - 1, 0));
            wdata  = $urandom;
            raddr0 = 5'($urandom_range(NREGS - 1, 0));
            raddr1 = (c % 4 == 0) ? waddr : 5'($urandom_range(NREGS - 1, 0));
            e0 = model[raddr0];
            e1 = model[raddr1];
            if (BYP && wen && waddr != '0 && raddr0 == waddr) e0 = wdata;
            if (BYP && wen && waddr != '0 && raddr1 == waddr) e1 = wdata;
            #1;
            chk($sformatf("rand%0d rdata0", c), rdata0, e0);
            chk($sformatf("rand%0d rdata1", c), rdata1, e1);
            step();
            if (wen && waddr != '0) model[waddr] = wdata;
        end
        wen = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
